multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle control unit for the RV32I datapath: replaces the single-cycle combinational opcode decoder with a state machine that sequences fetch, decode, execute, memory and write-back over several clocks. It adds a memory handshake with an optional timeout, branch support, and an illegal-opcode trap. It sits between the instruction register and the datapath muxes and strobes, and it drives the shared instruction/data memory port.

## Interface
Parameters:
- SUPPORT_BRANCH, 1, when 0 the opcode 1100011 is treated as illegal.
- HALT_ON_ILLEGAL, 1, when 1 an illegal opcode parks the FSM in TRAP; when 0 the FSM pulses `illegal` and returns to FETCH.
- MEM_TIMEOUT, 0, maximum number of wait cycles for `mem_ready`; 0 disables the timeout.
- TMO_W, 8, width of the wait counter; must satisfy 2^TMO_W > MEM_TIMEOUT.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0]
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access in this cycle
- pc_write  out  1  PC register enable
- pc_src  out  1  0 = PC+4, 1 = branch target
- ir_write  out  1  IR load enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALU result
- mem_read, mem_write  out  1 each  memory strobes
- alu_src  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  00 = I-ALU, 01 = address add, 10 = R-type funct decode, 11 = branch subtract
- mem_to_reg, reg_write  out  1 each  write-back controls
- illegal  out  1  illegal-opcode flag
- mem_err  out  1  memory timeout flag
- state  out  3  current state, for debug

## Operation
- Instruction classes: R = 0110011, I = 0010011, LOAD = 0000011, STORE = 0100011, BRANCH = 1100011. All other opcodes are illegal.
- The class is latched into `cls_q` at the end of DECODE. EXEC, MEM and WB use only `cls_q`.
- Encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.
- Outputs are a combinational decode of state and `cls_q` (plus `mem_ready` and `alu_zero` where noted). Any output not listed for a state is 0.
- FETCH:
  - Drives mem_read = 1 and i_or_d = 0.
  - When `mem_ready` is high, also drives ir_write = 1 and pc_write = 1 (pc_src = 0), then moves to DECODE. Otherwise stays in FETCH.
- DECODE:
  - Legal opcode: moves to EXEC.
  - Illegal opcode: moves to TRAP if HALT_ON_ILLEGAL = 1. Otherwise it asserts `illegal` for this cycle only and moves to FETCH.
- EXEC:
  - R: alu_src = 0, alu_op = 10, moves to WB.
  - I: alu_src = 1, alu_op = 00, moves to WB.
  - LOAD/STORE: alu_src = 1, alu_op = 01, moves to MEM.
  - BRANCH: alu_src = 0, alu_op = 11, pc_src = 1, pc_write = alu_zero, moves to FETCH.
- MEM:
  - Drives i_or_d = 1, with mem_read = 1 for LOAD or mem_write = 1 for STORE. The strobe is held until `mem_ready` is high.
  - On `mem_ready`, LOAD moves to WB and STORE moves to FETCH.
- WB: reg_write = 1, mem_to_reg = 1 if LOAD, moves to FETCH.
- TRAP:
  - Every strobe is 0 and `illegal` (or `mem_err`) is held at 1.
  - The FSM leaves TRAP only on reset.
- Timeout (MEM_TIMEOUT > 0):
  - The wait counter clears on entry to FETCH or MEM.
  - It increments on each cycle in those states with `mem_ready` low.
  - When it reaches MEM_TIMEOUT with `mem_ready` still low, the FSM moves to TRAP and sets `mem_err` (sticky). The access strobe drops in the TRAP cycle.
  - If `mem_ready` rises in the same cycle the count hits the limit, the access completes normally.

## Timing
- Reset values, while `rst_n` is low: state = FETCH, cls_q = R, counter = 0, illegal = 0, mem_err = 0. Every strobe output is forced to 0, even though FETCH decodes mem_read = 1.
- The first fetch request is made in the first cycle after `rst_n` deasserts.
- Latency with zero-wait memory (`mem_ready` always 1): R/I = 4 cycles, LOAD = 5, STORE = 4, BRANCH = 3. Each wait cycle adds 1.
- Reset asserted mid-access drops all strobes asynchronously. No partial write-back occurs.
- `opcode` is sampled only in DECODE.

## Structure
- `ctrl_pkg` holds:
  - the state enum
  - opcode localparams
  - the class enum
  - the alu_op encodings
- Sub-module `opcode_class_decoder` (combinational): takes opcode and SUPPORT_BRANCH, and produces the class and a legal bit. It is instantiated once and used in DECODE.

## Test plan
- R-type (0110011), `mem_ready` = 1: states go 0,1,2,4,0. Write-back has reg_write = 1, alu_op = 10 in EXEC, exactly 1 pc_write.
- LOAD with 3 wait cycles in MEM: mem_read and i_or_d stay 1 for 4 cycles. WB has mem_to_reg = 1. Total 8 cycles.
- BRANCH with alu_zero = 1, then with alu_zero = 0: pc_write pulses with pc_src = 1 only in the first case. With SUPPORT_BRANCH = 0 the opcode traps.
- Opcode 1111111 with HALT_ON_ILLEGAL = 1: `illegal` stays 1 in TRAP for 20 cycles with no strobes. With HALT_ON_ILLEGAL = 0: a 1-cycle `illegal` pulse, then FETCH.
- MEM_TIMEOUT = 4 and `mem_ready` held 0 in FETCH: TRAP is entered on the 5th cycle and `mem_err` = 1. With `mem_ready` rising on the 4th wait cycle, no trap occurs.
- Reset asserted in the middle of MEM during a STORE: mem_write drops immediately. After release, state = 0 and the fetch resumes.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control unit.
//   state_e : FSM states; the numeric values are visible on the debug port.
//   cls_e   : instruction class latched at the end of DECODE.
//   OPC_*   : major opcodes (IR[6:0]) recognised by the controller.
//   ALUOP_* : encodings driven on alu_op toward the ALU control decoder.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_I      = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4
    } cls_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_IALU  = 2'b00;
    localparam logic [1:0] ALUOP_ADDR  = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_SUB   = 2'b11;

endpackage

// File: rtl/opcode_class_decoder.sv
// Combinational opcode classifier.
//   opcode : IR[6:0]
//   cls    : instruction class (meaningful only when legal = 1)
//   legal  : opcode belongs to a supported class
// Branches are reported illegal when SUPPORT_BRANCH = 0.
module opcode_class_decoder
    import ctrl_pkg::*;
#(
    parameter int unsigned SUPPORT_BRANCH = 1
) (
    input  logic [6:0] opcode,
    output cls_e       cls,
    output logic       legal
);

    always_comb begin
        cls   = CLS_R;
        legal = 1'b1;
        case (opcode)
            OPC_R:      cls = CLS_R;
            OPC_I:      cls = CLS_I;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: begin
                cls   = CLS_BRANCH;
                legal = (SUPPORT_BRANCH != 0);
            end
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Inputs : clk, rst_n (async, active low), opcode (IR[6:0]), alu_zero,
//          mem_ready (memory finishes the current access this cycle).
// Outputs: datapath enables/selects (pc_write, pc_src, ir_write, i_or_d,
//          alu_src, alu_op, mem_to_reg, reg_write), memory strobes
//          (mem_read, mem_write), status flags (illegal, mem_err) and the
//          current state for debug.
// All control outputs are a combinational decode of state/cls_q and are
// forced low while rst_n is low so an access in flight is dropped at once.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned SUPPORT_BRANCH  = 1,
    parameter int unsigned HALT_ON_ILLEGAL = 1,
    parameter int unsigned MEM_TIMEOUT     = 0,
    parameter int unsigned TMO_W           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_src,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal,
    output logic       mem_err,
    output logic [2:0] state
);

    localparam bit              TMO_EN   = (MEM_TIMEOUT > 0);
    // Count value seen in the last allowed wait cycle.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_EN ? MEM_TIMEOUT - 1 : 0);

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             mem_err_q, mem_err_d;

    cls_e dec_cls;
    logic dec_legal;

    logic pc_write_c, pc_src_c, ir_write_c, i_or_d_c, mem_read_c, mem_write_c;
    logic alu_src_c, mem_to_reg_c, reg_write_c, ill_pulse_c, tmo_hit;
    logic [1:0] alu_op_c;

    opcode_class_decoder #(
        .SUPPORT_BRANCH(SUPPORT_BRANCH)
    ) u_dec (
        .opcode(opcode),
        .cls   (dec_cls),
        .legal (dec_legal)
    );

    // Limit reached while the memory is still stalling.
    assign tmo_hit = TMO_EN && !mem_ready && (cnt_q == TMO_LAST);

    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        illegal_d    = illegal_q;
        mem_err_d    = mem_err_q;
        pc_write_c   = 1'b0;
        pc_src_c     = 1'b0;
        ir_write_c   = 1'b0;
        i_or_d_c     = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        alu_src_c    = 1'b0;
        alu_op_c     = ALUOP_IALU;
        mem_to_reg_c = 1'b0;
        reg_write_c  = 1'b0;
        ill_pulse_c  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_read_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = ST_DECODE;
                end else if (tmo_hit) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    cls_d   = dec_cls;
                    state_d = ST_EXEC;
                end else if (HALT_ON_ILLEGAL != 0) begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    ill_pulse_c = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_R: begin
                        alu_op_c = ALUOP_FUNCT;
                        state_d  = ST_WB;
                    end
                    CLS_I: begin
                        alu_src_c = 1'b1;
                        state_d   = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_c = 1'b1;
                        alu_op_c  = ALUOP_ADDR;
                        state_d   = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op_c   = ALUOP_SUB;
                        pc_src_c   = 1'b1;
                        pc_write_c = alu_zero;
                        state_d    = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                i_or_d_c    = 1'b1;
                mem_read_c  = (cls_q == CLS_LOAD);
                mem_write_c = (cls_q == CLS_STORE);
                if (mem_ready) begin
                    state_d = (cls_q == CLS_LOAD) ? ST_WB : ST_FETCH;
                end else if (tmo_hit) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_TRAP;
                end
            end
            ST_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = (cls_q == CLS_LOAD);
                state_d      = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    // Wait counter runs only while an access (FETCH or MEM) is stalled; any
    // other cycle, including the one before entering FETCH/MEM, clears it.
    always_comb begin
        cnt_d = '0;
        if (TMO_EN && !mem_ready && (state_q == ST_FETCH || state_q == ST_MEM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_R;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign pc_write   = rst_n & pc_write_c;
    assign pc_src     = rst_n & pc_src_c;
    assign ir_write   = rst_n & ir_write_c;
    assign i_or_d     = rst_n & i_or_d_c;
    assign mem_read   = rst_n & mem_read_c;
    assign mem_write  = rst_n & mem_write_c;
    assign alu_src    = rst_n & alu_src_c;
    assign alu_op     = rst_n ? alu_op_c : 2'b00;
    assign mem_to_reg = rst_n & mem_to_reg_c;
    assign reg_write  = rst_n & reg_write_c;
    assign illegal    = rst_n & (illegal_q | ill_pulse_c);
    assign mem_err    = rst_n & mem_err_q;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Four instances cover the
// parameter corners: 0 = defaults, 1 = no branch support, 2 = illegal
// opcodes pulse instead of halting, 3 = MEM_TIMEOUT = 4. Each instruction is
// expanded by the reference model into the sequence of per-cycle output words
// the specification prescribes, then replayed against the DUT.
module tb_multicycle_controller;

    localparam int NCFG     = 4;
    localparam int TRAP_CYC = 20;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;

    // Observed word: {state[2:0], pc_write, pc_src, ir_write, i_or_d, mem_read,
    //                 mem_write, alu_src, alu_op[1:0], mem_to_reg, reg_write, illegal, mem_err}
    localparam logic [15:0] M_PCW = 16'h1000, M_PCS = 16'h0800, M_IRW = 16'h0400;
    localparam logic [15:0] M_IOD = 16'h0200, M_RD  = 16'h0100, M_WR  = 16'h0080;
    localparam logic [15:0] M_SRC = 16'h0040, A_ADDR = 16'h0010, A_FUNCT = 16'h0020;
    localparam logic [15:0] A_SUB = 16'h0030, M_M2R = 16'h0008, M_RW  = 16'h0004;
    localparam logic [15:0] M_ILL = 16'h0002, M_ERR = 16'h0001;

    typedef struct {
        bit          rdy_dc;
        bit          rdy;
        bit          is_dec;
        bit          z_care;
        bit          z;
        logic [15:0] exp;
    } cyc_t;

    logic       clk;
    logic       rst_n_s    [NCFG];
    logic [6:0] opcode_s   [NCFG];
    logic       alu_zero_s [NCFG];
    logic       mem_ready_s[NCFG];
    wire [15:0] obs_w      [NCFG];

    int   checks = 0;
    int   errors = 0;
    cyc_t trace_q[$];
    bit   trace_trap;

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
        multicycle_controller #(
            .SUPPORT_BRANCH ((gi == 1) ? 0 : 1),
            .HALT_ON_ILLEGAL((gi == 2) ? 0 : 1),
            .MEM_TIMEOUT    ((gi == 3) ? 4 : 0),
            .TMO_W          (8)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n_s[gi]),
            .opcode    (opcode_s[gi]),
            .alu_zero  (alu_zero_s[gi]),
            .mem_ready (mem_ready_s[gi]),
            .pc_write  (obs_w[gi][12]),
            .pc_src    (obs_w[gi][11]),
            .ir_write  (obs_w[gi][10]),
            .i_or_d    (obs_w[gi][9]),
            .mem_read  (obs_w[gi][8]),
            .mem_write (obs_w[gi][7]),
            .alu_src   (obs_w[gi][6]),
            .alu_op    (obs_w[gi][5:4]),
            .mem_to_reg(obs_w[gi][3]),
            .reg_write (obs_w[gi][2]),
            .illegal   (obs_w[gi][1]),
            .mem_err   (obs_w[gi][0]),
            .state     (obs_w[gi][15:13])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic bit cfg_sb(int k);    return k != 1;           endfunction
    function automatic bit cfg_halt(int k);  return k != 2;           endfunction
    function automatic int cfg_tmo(int k);   return (k == 3) ? 4 : 0; endfunction
    function automatic logic [15:0] st(int n); return 16'(n) << 13;   endfunction

    // -1 = illegal, else 0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH
    function automatic int classify(logic [6:0] op, bit sb);
        case (op)
            OP_R:    return 0;
            OP_I:    return 1;
            OP_LD:   return 2;
            OP_ST:   return 3;
            OP_BR:   return sb ? 4 : -1;
            default: return -1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit rdy_dc, input bit rdy, input bit is_dec,
                        input bit z_care, input bit z, input logic [15:0] exp);
        cyc_t e;
        e.rdy_dc = rdy_dc; e.rdy = rdy; e.is_dec = is_dec;
        e.z_care = z_care; e.z = z;     e.exp = exp;
        trace_q.push_back(e);
    endtask

    task automatic push_trap(input logic [15:0] flag);
        for (int i = 0; i < TRAP_CYC; i++) push(1, 0, 0, 0, 0, st(5) | flag);
        trace_trap = 1;
    endtask

    // A memory access stalled for `waits` cycles; traps once the stall count
    // reaches the timeout limit, otherwise completes with `done_extra` set.
    task automatic push_access(input int k, input int waits, input logic [15:0] word,
                               input logic [15:0] done_extra, output bit ok);
        int  lim   = cfg_tmo(k);
        bit  times = (lim > 0) && (waits >= lim);
        int  n     = times ? lim : waits;
        for (int i = 0; i < n; i++) push(0, 0, 0, 0, 0, word);
        if (times) begin
            push_trap(M_ERR);
            ok = 0;
        end else begin
            push(0, 1, 0, 0, 0, word | done_extra);
            ok = 1;
        end
    endtask

    task automatic build(input int k, input logic [6:0] op, input int fw, input int mw, input bit z);
        bit ok;
        int c;
        trace_q.delete();
        trace_trap = 0;
        push_access(k, fw, st(0) | M_RD, M_IRW | M_PCW, ok);
        if (!ok) return;
        c = classify(op, cfg_sb(k));
        if (c < 0) begin
            push(1, 0, 1, 0, 0, st(1) | (cfg_halt(k) ? 16'h0 : M_ILL));
            if (cfg_halt(k)) push_trap(M_ILL);
            return;
        end
        push(1, 0, 1, 0, 0, st(1));
        case (c)
            0: begin push(1, 0, 0, 0, 0, st(2) | A_FUNCT); push(1, 0, 0, 0, 0, st(4) | M_RW); end
            1: begin push(1, 0, 0, 0, 0, st(2) | M_SRC);   push(1, 0, 0, 0, 0, st(4) | M_RW); end
            2: begin
                push(1, 0, 0, 0, 0, st(2) | M_SRC | A_ADDR);
                push_access(k, mw, st(3) | M_IOD | M_RD, 16'h0, ok);
                if (ok) push(1, 0, 0, 0, 0, st(4) | M_RW | M_M2R);
            end
            3: begin
                push(1, 0, 0, 0, 0, st(2) | M_SRC | A_ADDR);
                push_access(k, mw, st(3) | M_IOD | M_WR, 16'h0, ok);
            end
            default: push(1, 0, 0, 1, z, st(2) | A_SUB | M_PCS | (z ? M_PCW : 16'h0));
        endcase
    endtask

    // Entered and left at 2 time units after a rising edge.
    task automatic run_q(input int k, input logic [6:0] op, input int n);
        int lim = (n < 0 || n > trace_q.size()) ? trace_q.size() : n;
        for (int i = 0; i < lim; i++) begin
            mem_ready_s[k] = trace_q[i].rdy_dc ? 1'($urandom) : trace_q[i].rdy;
            opcode_s[k]    = trace_q[i].is_dec ? op : 7'($urandom);
            alu_zero_s[k]  = trace_q[i].z_care ? trace_q[i].z : 1'($urandom);
            #1;
            check($sformatf("cfg%0d op%b cyc%0d", k, op, i), obs_w[k], trace_q[i].exp);
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset(input int k);
        rst_n_s[k] = 1'b0;
        #1;
        check($sformatf("cfg%0d rst_async", k), obs_w[k], 16'h0);
        @(posedge clk);
        #2;
        check($sformatf("cfg%0d rst_hold", k), obs_w[k], 16'h0);
        @(posedge clk);
        #2;
        rst_n_s[k] = 1'b1;
    endtask

    task automatic do_txn(input int k, input logic [6:0] op, input int fw, input int mw, input bit z);
        build(k, op, fw, mw, z);
        run_q(k, op, -1);
        $display("txn cfg=%0d op=%b fw=%0d mw=%0d z=%0d cycles=%0d trap=%0d",
                 k, op, fw, mw, z, trace_q.size(), trace_trap);
        if (trace_trap) do_reset(k);
    endtask

    initial begin
        logic [6:0] op;
        for (int k = 0; k < NCFG; k++) begin
            rst_n_s[k] = 1'b0; opcode_s[k] = '0; alu_zero_s[k] = 1'b0; mem_ready_s[k] = 1'b0;
        end
        @(posedge clk);
        #2;
        for (int k = 0; k < NCFG; k++) begin
            do_reset(k);
            case (k)
                0: begin
                    do_txn(0, OP_R, 0, 0, 0);
                    do_txn(0, OP_LD, 0, 3, 0);
                    do_txn(0, OP_ST, 0, 0, 0);
                    do_txn(0, OP_BR, 0, 0, 1);
                    do_txn(0, OP_BR, 0, 0, 0);
                    do_txn(0, OP_I, 2, 0, 0);
                    do_txn(0, OP_BAD, 0, 0, 0);
                    // Reset in the middle of a stalled STORE.
                    build(0, OP_ST, 0, 6, 0);
                    run_q(0, OP_ST, 5);
                    mem_ready_s[0] = 1'b0;
                    #1;
                    check("cfg0 mid_store", obs_w[0], st(3) | M_IOD | M_WR);
                    do_reset(0);
                    do_txn(0, OP_R, 0, 0, 0);
                end
                1: begin
                    do_txn(1, OP_BR, 0, 0, 1);
                    do_txn(1, OP_R, 0, 0, 0);
                end
                2: begin
                    do_txn(2, OP_BAD, 0, 0, 0);
                    do_txn(2, OP_R, 0, 0, 0);
                end
                default: begin
                    do_txn(3, OP_R, 4, 0, 0);
                    do_txn(3, OP_R, 3, 0, 0);
                    do_txn(3, OP_LD, 0, 4, 0);
                    do_txn(3, OP_LD, 1, 3, 0);
                end
            endcase
            for (int t = 0; t < 40; t++) begin
                case ($urandom_range(0, 6))
                    0: op = OP_R;
                    1: op = OP_I;
                    2: op = OP_LD;
                    3: op = OP_ST;
                    4, 5: op = OP_BR;
                    default: op = 7'($urandom);
                endcase
                do_txn(k, op, int'($urandom_range(0, (k == 3) ? 5 : 3)),
                       int'($urandom_range(0, (k == 3) ? 5 : 3)), 1'($urandom));
            end
            rst_n_s[k] = 1'b0;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
